spi_master: RTL and testbench



---
 rtl/spi_master.sv | 171 +++++++++++++++++
 tb/tb_spi_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_master: SPI mode-0 master, MSB first, one DATA_W frame per cs low |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_master #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX = (MAX_SH > CS_IDLE) ? MAX_SH : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(DATA_W);

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
  logic [DATA_W-1:0] rx_sh, rx_sh_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              cs_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic              setup_end, div_end, last_bit, shift_end, hold_end, gap_end;

  assign setup_end = (cnt == CNT_W'(CS_SETUP - 1));
  assign hold_end  = (cnt == CNT_W'(CS_HOLD - 1));
  assign gap_end   = (cnt == CNT_W'(CS_IDLE - 1));
  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
  // The frame ends after the low half of the last bit, not at its falling edge.
  assign shift_end = div_end && !sck && last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      cs      <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sh   <= tx_sh_nxt;
      rx_sh   <= rx_sh_nxt;
      rx_data <= rx_data_nxt;
      cs      <= cs_nxt;
      sck     <= sck_nxt;
      mosi    <= mosi_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_SETUP;
      S_SETUP: if (setup_end) state_nxt = S_SHIFT;
      S_SHIFT: if (shift_end) state_nxt = S_HOLD;
      S_HOLD:  if (hold_end)  state_nxt = S_GAP;
      S_GAP:   if (gap_end)   state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt     = cnt + CNT_W'(1);
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    tx_sh_nxt   = tx_sh;
    rx_sh_nxt   = rx_sh;
    rx_data_nxt = rx_data;
    cs_nxt      = cs;
    sck_nxt     = sck;
    mosi_nxt    = mosi;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    if (state_nxt != state || state == S_IDLE || state == S_SHIFT)
      cnt_nxt = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          tx_sh_nxt = tx_data;
          rx_sh_nxt = '0;
          mosi_nxt  = tx_data[DATA_W-1];
          cs_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      S_SETUP: begin
        if (setup_end) begin
          sck_nxt     = 1'b1;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_nxt = '0;
          if (sck) begin
            // Sample as late as possible: on the edge that drops sck.
            sck_nxt   = 1'b0;
            rx_sh_nxt = {rx_sh[DATA_W-2:0], miso};
            if (!last_bit) begin
              tx_sh_nxt = {tx_sh[DATA_W-2:0], 1'b0};
              mosi_nxt  = tx_sh[DATA_W-2];
            end
          end else if (!last_bit) begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            sck_nxt     = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hold_end) begin
          cs_nxt      = 1'b1;
          mosi_nxt    = 1'b0;
          done_nxt    = 1'b1;
          rx_data_nxt = rx_sh;
        end
      end
      S_GAP: begin
        if (gap_end) busy_nxt = 1'b0;
      end
      default: begin
        cs_nxt   = 1'b1;
        sck_nxt  = 1'b0;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_spi_master: randomized frames against a word-level SPI model       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_spi_master;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0, start2 = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         loop = 1'b1;
  logic         slv_bit = 1'b0;

  logic         busy1, done1, cs1, sck1, mosi1, miso1;
  logic         busy2, done2, cs2, sck2, mosi2, miso2;
  logic [W-1:0] rx1, rx2;

  int           cur = 0;
  logic         obs_cs, obs_sck, obs_mosi, obs_busy, obs_done;
  logic [W-1:0] obs_rx;

  int total = 0;
  int bad = 0;
  int hi_run = 0;
  int last_hi_run = 0;

  always #5 clk = ~clk;

  assign miso1 = loop ? mosi1 : slv_bit;
  assign miso2 = loop ? mosi2 : slv_bit;

  spi_master #(.DATA_W(W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data),
    .busy(busy1), .done(done1), .rx_data(rx1),
    .cs(cs1), .sck(sck1), .mosi(mosi1), .miso(miso1)
  );

  spi_master #(.DATA_W(W), .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data),
    .busy(busy2), .done(done2), .rx_data(rx2),
    .cs(cs2), .sck(sck2), .mosi(mosi2), .miso(miso2)
  );

  always_comb begin
    obs_cs   = (cur == 1) ? cs2   : cs1;
    obs_sck  = (cur == 1) ? sck2  : sck1;
    obs_mosi = (cur == 1) ? mosi2 : mosi1;
    obs_busy = (cur == 1) ? busy2 : busy1;
    obs_done = (cur == 1) ? done2 : done1;
    obs_rx   = (cur == 1) ? rx2   : rx1;
  end

  // Length of the most recent completed cs-high stretch of the first instance.
  always @(negedge clk) begin
    if (cs1) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0) last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur == 1) start2 = v;
    else          start1 = v;
  endtask

  // One frame, observed cycle by cycle; expectations come from timing arithmetic
  // and the word-level rule "mosi carries tx MSB first, rx_data equals what miso carried".
  task automatic run_frame(input logic [W-1:0] tx, input logic [W-1:0] rsp, input bit lb,
                           input bit keep, input int pulse_at, input string tag);
    int div, setup, hold, idle, len;
    int cs_first, cs_last, done_cyc, done_n, busy_low, rises, run, bad_half, sck_hi;
    logic prev_sck;
    logic [W-1:0] mosi_word;
    div   = (cur == 1) ? 2 : 4;
    setup = (cur == 1) ? 2 : 4;
    hold  = (cur == 1) ? 2 : 4;
    idle  = (cur == 1) ? 2 : 4;
    len   = setup + 2 * div * W + hold;
    cs_first = 0; cs_last = 0; done_cyc = 0; done_n = 0; busy_low = 0;
    rises = 0; run = 0; bad_half = 0; sck_hi = 0;
    prev_sck = 1'b0; mosi_word = '0;
    loop = lb; slv_bit = 1'b0;
    tx_data = tx;
    set_start(1'b1);
    @(posedge clk); #1;
    if (!keep) set_start(1'b0);
    tx_data = W'($urandom);
    for (int k = 1; k <= 400 && busy_low == 0; k++) begin
      @(negedge clk);
      if (pulse_at != 0 && k == pulse_at) set_start(1'b1);
      if (pulse_at != 0 && k == pulse_at + 1) set_start(1'b0);
      if (!obs_cs) begin
        if (cs_first == 0) cs_first = k;
        cs_last = k;
      end
      if (obs_done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (obs_sck !== prev_sck) begin
        if (!obs_sck || rises > 0) if (run != div) bad_half++;
        if (obs_sck) begin
          rises++;
          mosi_word = {mosi_word[W-2:0], obs_mosi};
          if (rises <= W) slv_bit = rsp[W-rises];
        end
        run = 1;
      end else begin
        run++;
      end
      if (obs_sck && obs_cs) sck_hi++;
      if (!obs_busy) busy_low = k;
      prev_sck = obs_sck;
    end
    check({tag, ".cs_first"}, cs_first, 1);
    check({tag, ".cs_last"}, cs_last, len);
    check({tag, ".done_cyc"}, done_cyc, len + 1);
    check({tag, ".done_n"}, done_n, 1);
    check({tag, ".busy_low"}, busy_low, len + 1 + idle);
    check({tag, ".rises"}, rises, W);
    check({tag, ".mosi"}, mosi_word, tx);
    check({tag, ".rx"}, obs_rx, lb ? tx : rsp);
    check({tag, ".half"}, bad_half, 0);
    check({tag, ".sck_cs_hi"}, sck_hi, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    int falls;
    logic prv;
    cur = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst0.cs", cs1, 1);
    check("rst0.sck", sck1, 0);
    check("rst0.mosi", mosi1, 0);
    check("rst0.busy", busy1, 0);
    check("rst0.done", done1, 0);
    check("rst0.rx", rx1, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(8'hA5, 8'h00, 1'b1, 1'b0, 0, "lb_a5");
    run_frame(8'hC3, 8'h3C, 1'b0, 1'b0, 0, "slv_c3");
    for (int i = 0; i < 6; i++)
      run_frame(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, "rnd");

    run_frame(8'h96, 8'h00, 1'b1, 1'b1, 0, "held1");
    run_frame(8'h69, 8'h00, 1'b1, 1'b0, 0, "held2");
    check("cs_gap", last_hi_run, 5);

    run_frame(8'h3C, 8'h00, 1'b1, 1'b0, 30, "pulse");
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy1 || !cs1) extra++;
    end
    check("no_queue", extra, 0);

    loop = 1'b1;
    tx_data = 8'hE7;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    falls = 0;
    prv = 1'b0;
    for (int k = 0; k < 200 && falls < 3; k++) begin
      @(negedge clk);
      if (prv && !sck1) falls++;
      prv = sck1;
    end
    check("abort.falls", falls, 3);
    #2 rst = 1'b1;
    #1;
    check("rst1.cs", cs1, 1);
    check("rst1.sck", sck1, 0);
    check("rst1.mosi", mosi1, 0);
    check("rst1.busy", busy1, 0);
    check("rst1.done", done1, 0);
    check("rst1.rx", rx1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(8'h5A, 8'h00, 1'b1, 1'b0, 0, "post_rst");

    cur = 1;
    run_frame(8'hFF, 8'h00, 1'b1, 1'b0, 0, "d2_ff");
    run_frame(8'h00, 8'h00, 1'b1, 1'b0, 0, "d2_00");
    for (int i = 0; i < 3; i++)
      run_frame(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, "d2_rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
